// File: rtl/fb_write_scheduler.sv
// Sole owner of the frame buffer write port: per-frame background clear, otherwise
// round-robin arbitration of pixel writes from NUM_REQ requesters.
module fb_write_scheduler #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned FB_DEPTH = 307200,
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned DATA_W   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_start,
  input  logic                      clear_en,
  input  logic [DATA_W-1:0]         clear_color,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [ADDR_W-1:0]         fb_wraddress,
  output logic [DATA_W-1:0]         fb_data,
  output logic                      fb_wren,
  output logic                      clearing,
  output logic                      clear_done,
  output logic [7:0]                overrun_count
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FB_DEPTH - 1);

  typedef enum logic [0:0] {StArb, StClear} state_e;

  state_e            state_q;
  logic [PtrW-1:0]   rr_ptr_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [DATA_W-1:0] color_q;

  logic              found;
  logic [PtrW-1:0]   sel;
  logic [PtrW-1:0]   next_ptr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              start_clear;

  assign start_clear = frame_start && clear_en;

  // Scan from rr_ptr upward, wrapping, and take the first active request.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned idx;
      idx = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        sel      = PtrW'(idx);
        sel_addr = req_addr[idx*ADDR_W +: ADDR_W];
        sel_data = req_data[idx*DATA_W +: DATA_W];
      end
    end
  end

  assign next_ptr = (sel == PtrW'(NUM_REQ - 1)) ? '0 : sel + PtrW'(1);

  always_comb begin
    grant = '0;
    if (!reset && state_q == StArb && !start_clear && found) begin
      grant = NUM_REQ'(1) << sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StArb;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      color_q       <= '0;
      fb_wraddress  <= '0;
      fb_data       <= '0;
      fb_wren       <= 1'b0;
      clearing      <= 1'b0;
      clear_done    <= 1'b0;
      overrun_count <= '0;
    end else begin
      clear_done <= 1'b0;
      unique case (state_q)
        StArb: begin
          if (start_clear) begin
            state_q  <= StClear;
            cnt_q    <= '0;
            color_q  <= clear_color;
            fb_wren  <= 1'b0;
            clearing <= 1'b1;
          end else begin
            clearing <= 1'b0;
            if (found) begin
              fb_wraddress <= sel_addr;
              fb_data      <= sel_data;
              // Out-of-range requests are consumed but never written.
              fb_wren      <= (32'(sel_addr) < FB_DEPTH);
              rr_ptr_q     <= next_ptr;
            end else begin
              fb_wren <= 1'b0;
            end
          end
        end
        StClear: begin
          fb_wraddress <= cnt_q;
          fb_data      <= color_q;
          fb_wren      <= 1'b1;
          clearing     <= 1'b1;
          // A new frame restarts the clear, even on its final write.
          if (frame_start) begin
            cnt_q   <= '0;
            color_q <= clear_color;
            if (overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;
          end else if (cnt_q == LastAddr) begin
            cnt_q      <= '0;
            state_q    <= StArb;
            clear_done <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        default: state_q <= StArb;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed bench for fb_write_scheduler using a reduced frame buffer depth.
module tb_fb_write_scheduler;

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned FB_DEPTH = 6000;
  localparam int unsigned ADDR_W   = 19;
  localparam int unsigned DATA_W   = 8;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      frame_start;
  logic                      clear_en;
  logic [DATA_W-1:0]         clear_color;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic [ADDR_W-1:0]         fb_wraddress;
  logic [DATA_W-1:0]         fb_data;
  logic                      fb_wren;
  logic                      clearing;
  logic                      clear_done;
  logic [7:0]                overrun_count;

  int checks   = 0;
  int failures = 0;

  fb_write_scheduler #(
    .NUM_REQ (NUM_REQ),
    .FB_DEPTH(FB_DEPTH),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .clear_en     (clear_en),
    .clear_color  (clear_color),
    .req          (req),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .grant        (grant),
    .fb_wraddress (fb_wraddress),
    .fb_data      (fb_data),
    .fb_wren      (fb_wren),
    .clearing     (clearing),
    .clear_done   (clear_done),
    .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int unsigned addr, input int unsigned data);
    req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    req_data[i*DATA_W +: DATA_W] = DATA_W'(data);
  endtask

  task automatic do_reset();
    reset = 1'b1; frame_start = 1'b0; clear_en = 1'b0; clear_color = '0;
    req = '0; req_addr = '0; req_data = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      #1;
      if (fb_wren !== 1'b0 || grant !== 4'b0000 || clearing !== 1'b0 ||
          overrun_count !== 8'd0 || clear_done !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_idle bad_cycles=%0d exp=0", bad);
    end
    checks++;
    if (fb_wraddress !== '0 || fb_data !== '0) begin
      failures++;
      $display("FAIL reset_regs addr=%0d data=%0h exp=0/0", fb_wraddress, fb_data);
    end
  endtask

  task automatic test_round_robin();
    int unsigned addrs[4] = '{10, 20, 30, 40};
    logic [3:0] exp_g;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, addrs[i], 'hA1 + i);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      exp_g = 4'b0001 << (k % 4);
      checks++;
      if (grant !== exp_g) begin
        failures++;
        $display("FAIL rr_grant k=%0d got=%b exp=%b", k, grant, exp_g);
      end
      tick();
      checks++;
      if (fb_wraddress !== ADDR_W'(addrs[k%4]) || fb_data !== DATA_W'('hA1 + k % 4) ||
          fb_wren !== 1'b1) begin
        failures++;
        $display("FAIL rr_write k=%0d got=%0d/%0h/%b exp=%0d/%0h/1", k, fb_wraddress,
                 fb_data, fb_wren, addrs[k%4], 'hA1 + k % 4);
      end
    end
    req = '0;
  endtask

  task automatic test_ptr_and_range();
    do_reset();
    set_req(0, 100, 'h01); set_req(1, 101, 'h02); set_req(3, FB_DEPTH, 'h04);
    req = 4'b0010;           // grant 1 moves rr_ptr to 2
    tick();
    req = 4'b0011;
    #1;
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL ptr2_first got=%b exp=0001", grant);
    end
    tick();
    req = 4'b0010;
    #1;
    checks++;
    if (grant !== 4'b0010) begin
      failures++;
      $display("FAIL ptr2_second got=%b exp=0010", grant);
    end
    tick();
    req = 4'b1000;
    #1;
    checks++;
    if (grant !== 4'b1000) begin
      failures++;
      $display("FAIL oor_grant got=%b exp=1000", grant);
    end
    tick();
    checks++;
    if (fb_wren !== 1'b0) begin
      failures++;
      $display("FAIL oor_wren got=%b exp=0", fb_wren);
    end
    req = 4'b1001;           // consumed slot advanced rr_ptr to 0
    #1;
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL oor_advance got=%b exp=0001", grant);
    end
    req = '0;
  endtask

  task automatic test_clear();
    int bad_g = 0, bad_w = 0;
    do_reset();
    set_req(0, 7, 'h55);
    req = 4'b0001; clear_en = 1'b1; frame_start = 1'b1; clear_color = 8'h1C;
    #1;
    if (grant !== 4'b0000) bad_g++;
    tick();
    frame_start = 1'b0; clear_color = 8'hFF;
    for (int i = 0; i < int'(FB_DEPTH); i++) begin
      if (grant !== 4'b0000 || clearing !== 1'b1) bad_g++;
      tick();
      if (fb_wraddress !== ADDR_W'(i) || fb_data !== 8'h1C || fb_wren !== 1'b1 ||
          clear_done !== (i == int'(FB_DEPTH) - 1)) bad_w++;
    end
    checks++;
    if (bad_g != 0) begin
      failures++;
      $display("FAIL clear_grant_block bad_cycles=%0d exp=0", bad_g);
    end
    checks++;
    if (bad_w != 0) begin
      failures++;
      $display("FAIL clear_writes bad_cycles=%0d exp=0", bad_w);
    end
    checks++;
    if (grant !== 4'b0001 || clearing !== 1'b1) begin
      failures++;
      $display("FAIL clear_exit grant=%b clearing=%b exp=0001/1", grant, clearing);
    end
    tick();
    checks++;
    if (fb_wraddress !== 19'd7 || fb_data !== 8'h55 || fb_wren !== 1'b1 ||
        clear_done !== 1'b0 || clearing !== 1'b0) begin
      failures++;
      $display("FAIL clear_resume got=%0d/%0h/%b/%b/%b exp=7/55/1/0/0", fb_wraddress,
               fb_data, fb_wren, clear_done, clearing);
    end
    req = '0;
  endtask

  task automatic test_overrun();
    int n;
    do_reset();
    clear_en = 1'b1; frame_start = 1'b1; clear_color = 8'h11;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 1000; i++) tick();
    frame_start = 1'b1; clear_color = 8'hE0; clear_en = 1'b0;
    tick();
    frame_start = 1'b0;
    checks++;
    if (fb_wraddress !== 19'd1000 || fb_data !== 8'h11 || overrun_count !== 8'd1) begin
      failures++;
      $display("FAIL overrun_edge got=%0d/%0h/%0d exp=1000/11/1", fb_wraddress, fb_data,
               overrun_count);
    end
    tick();
    checks++;
    if (fb_wraddress !== 19'd0 || fb_data !== 8'hE0 || clearing !== 1'b1) begin
      failures++;
      $display("FAIL overrun_restart got=%0d/%0h/%b exp=0/e0/1", fb_wraddress, fb_data,
               clearing);
    end
    frame_start = 1'b1;
    for (int i = 0; i < 260; i++) tick();
    frame_start = 1'b0;
    checks++;
    if (overrun_count !== 8'd255) begin
      failures++;
      $display("FAIL overrun_saturate got=%0d exp=255", overrun_count);
    end
    // Land a new frame exactly on the final clear write.
    for (int i = 0; i < int'(FB_DEPTH) - 1; i++) tick();
    frame_start = 1'b1; clear_color = 8'h33;
    tick();
    frame_start = 1'b0;
    checks++;
    if (fb_wraddress !== ADDR_W'(FB_DEPTH - 1) || clear_done !== 1'b0 || clearing !== 1'b1) begin
      failures++;
      $display("FAIL last_restart got=%0d/%b/%b exp=%0d/0/1", fb_wraddress, clear_done,
               clearing, FB_DEPTH - 1);
    end
    tick();
    checks++;
    if (fb_wraddress !== 19'd0 || fb_data !== 8'h33) begin
      failures++;
      $display("FAIL last_restart_addr got=%0d/%0h exp=0/33", fb_wraddress, fb_data);
    end
    n = 0;
    while (clear_done !== 1'b1 && n < int'(FB_DEPTH) + 10) begin
      tick();
      n++;
    end
    checks++;
    if (n != int'(FB_DEPTH) - 1) begin
      failures++;
      $display("FAIL restart_length got=%0d exp=%0d", n, FB_DEPTH - 1);
    end
  endtask

  task automatic test_reset_mid_clear();
    do_reset();
    set_req(2, 55, 'h77);
    req = 4'b0100; clear_en = 1'b1; frame_start = 1'b1; clear_color = 8'h9A;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 5000; i++) tick();
    reset = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0000) begin
      failures++;
      $display("FAIL reset_grant got=%b exp=0000", grant);
    end
    tick();
    reset = 1'b0;
    checks++;
    if (fb_wren !== 1'b0 || clearing !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got=%b/%b exp=0/0", fb_wren, clearing);
    end
    #1;
    checks++;
    if (grant !== 4'b0100) begin
      failures++;
      $display("FAIL post_reset_grant got=%b exp=0100", grant);
    end
    tick();
    req = '0;
    checks++;
    if (fb_wraddress !== 19'd55 || fb_data !== 8'h77 || fb_wren !== 1'b1 || clearing !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_write got=%0d/%0h/%b/%b exp=55/77/1/0", fb_wraddress,
               fb_data, fb_wren, clearing);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_ptr_and_range();
    test_clear();
    test_overrun();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
